// File: rtl/wheel_period_meter.sv
// wheel_period_meter: filters the wheel hall sensor and measures the
// rotation period in clk cycles, with a stall flag and a revolution count.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   hall_in       raw sensor pin, asynchronous to clk, may bounce
//   period        cycles between the last two accepted edges
//   period_valid  one-cycle strobe, period updated this cycle
//   stalled       no edge within TIMEOUT_CYCLES, or none since reset
//   rev_count     accepted-edge counter, wraps silently
module wheel_period_meter #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned TIMEOUT_CYCLES    = 100000000,
    parameter int unsigned PERIOD_W          = 27,
    parameter bit          SENSOR_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hall_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled,
    output logic [15:0]         rev_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic INACTIVE = SENSOR_ACTIVE_LOW;
    localparam logic ACTIVE   = ~SENSOR_ACTIVE_LOW;
    localparam logic [DB_W-1:0] DB_LAST =
        DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] TIMEOUT =
        PERIOD_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    logic            sync_a;
    logic            sync_b;
    logic            filt;
    logic            edge_stb;
    logic [DB_W-1:0] cnt_db;

    state_t              state;
    logic [PERIOD_W-1:0] cnt_p;

    // Synchronizer and debounce. A level is accepted only after the
    // synchronized input has differed from filt for DEBOUNCE_CYCLES
    // consecutive cycles; any return to filt restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= INACTIVE;
            sync_b   <= INACTIVE;
            filt     <= INACTIVE;
            cnt_db   <= '0;
            edge_stb <= 1'b0;
        end else begin
            sync_a   <= hall_in;
            sync_b   <= sync_a;
            edge_stb <= 1'b0;
            if (sync_b == filt) begin
                cnt_db <= '0;
            end else if (cnt_db == DB_LAST) begin
                filt     <= sync_b;
                cnt_db   <= '0;
                // sync_b differs from filt here, so this is
                // exactly the inactive->active transition.
                edge_stb <= (sync_b == ACTIVE);
            end else begin
                cnt_db <= cnt_db + DB_W'(1);
            end
        end
    end

    // Period measurement. cnt_p restarts at 1 on each edge so that
    // edges N cycles apart read back as N. An edge arriving in the
    // timeout cycle takes priority over the stall transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt_p        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b1;
            rev_count    <= '0;
        end else begin
            period_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt_p <= '0;
                    if (edge_stb) begin
                        state     <= MEASURE;
                        cnt_p     <= PERIOD_W'(1);
                        stalled   <= 1'b0;
                        rev_count <= rev_count + 16'd1;
                    end
                end
                MEASURE: begin
                    if (edge_stb) begin
                        period       <= cnt_p;
                        period_valid <= 1'b1;
                        cnt_p        <= PERIOD_W'(1);
                        rev_count    <= rev_count + 16'd1;
                    end else if (cnt_p == TIMEOUT) begin
                        state   <= IDLE;
                        stalled <= 1'b1;
                        cnt_p   <= '0;
                    end else begin
                        cnt_p <= cnt_p + PERIOD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
